// File: rtl/boot_stream_loader_pkg.sv
// boot_stream_loader_pkg: shared destination/state types and default channel geometry
package boot_stream_loader_pkg;
  typedef enum logic [2:0] {IMEM = 3'b100, DMEM = 3'b010, IB = 3'b001} dest_t;
  typedef enum logic [1:0] {IDLE, LEN_LO, LEN_HI, PAYLOAD} boot_state_t;
  localparam int BPW_IMEM_DEF = 4;
  localparam int BPW_DMEM_DEF = 4;
  localparam int BPW_IB_DEF = 384;
  localparam int DEPTH_IMEM_DEF = 2048;
  localparam int DEPTH_DMEM_DEF = 8192;
  localparam int DEPTH_IB_DEF = 256;
endpackage

// File: rtl/boot_stream_loader_if.sv
// boot_stream_loader_if: UART byte input, abort, memory write strobes and status
interface boot_stream_loader_if #(parameter int AW = 13, parameter int DW = 3072);
  logic abort;
  logic rx_vld;
  logic [7:0] rx_data;
  logic imem_we;
  logic dmem_we;
  logic ib_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic busy;
  logic done;
  logic err;
  modport master (output abort, rx_vld, rx_data, input imem_we, dmem_we, ib_we, wr_addr, wr_data, busy, done, err);
  modport slave (input abort, rx_vld, rx_data, output imem_we, dmem_we, ib_we, wr_addr, wr_data, busy, done, err);
endinterface

// File: rtl/boot_stream_loader_packer.sv
// byte_packer: little-endian byte-lane assembly with a separate write register and one-cycle ready flag
module byte_packer #(
  parameter int DW = 3072,
  parameter int BW = $clog2(DW/8)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_we,
  input  logic i_last,
  input  logic [BW-1:0] i_idx,
  input  logic [7:0] i_byte,
  output logic [DW-1:0] o_word,
  output logic o_rdy
);
  logic [DW-1:0] r_asm, r_word, w_merged;
  logic r_rdy;
  always_comb begin
    w_merged = r_asm;
    w_merged[{i_idx, 3'b000} +: 8] = i_byte;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_asm <= '0;
      r_word <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= i_we && i_last;
      if (i_clr) r_asm <= '0;
      else if (i_we && i_last) begin
        r_asm <= '0;
        r_word <= w_merged;
      end else if (i_we) r_asm[{i_idx, 3'b000} +: 8] <= i_byte;
    end
  end
  assign o_word = r_word;
  assign o_rdy = r_rdy;
endmodule

// File: rtl/boot_stream_loader.sv
// boot_stream_loader: header/length/payload FSM turning a UART byte stream into per-destination word writes
module boot_stream_loader
  import boot_stream_loader_pkg::*;
#(
  parameter int BPW_IMEM = BPW_IMEM_DEF,
  parameter int BPW_DMEM = BPW_DMEM_DEF,
  parameter int BPW_IB = BPW_IB_DEF,
  parameter int DEPTH_IMEM = DEPTH_IMEM_DEF,
  parameter int DEPTH_DMEM = DEPTH_DMEM_DEF,
  parameter int DEPTH_IB = DEPTH_IB_DEF,
  parameter int AW = 13,
  parameter int DW = 3072
) (
  input logic clk,
  input logic rst_n,
  boot_stream_loader_if.slave bus
);
  localparam int BW = $clog2(DW/8);
  boot_state_t r_state, w_next;
  dest_t r_dest;
  logic [7:0] r_len_lo;
  logic [15:0] r_len, r_wcnt, w_len;
  logic [BW-1:0] r_bcnt;
  logic [AW-1:0] r_addr;
  logic r_done, r_err;
  logic w_acc, w_hdr_ok, w_last_byte, w_last_word, w_start, w_pay, w_rdy;
  logic [DW-1:0] w_word;
  int w_bpw, w_depth;
  always_comb begin
    w_acc = bus.rx_vld && !bus.abort;
    w_pay = w_acc && r_state == PAYLOAD;
    w_hdr_ok = bus.rx_data inside {8'h04, 8'h02, 8'h01};
    w_bpw = r_dest == IMEM ? BPW_IMEM : r_dest == DMEM ? BPW_DMEM : BPW_IB;
    w_depth = r_dest == IMEM ? DEPTH_IMEM : r_dest == DMEM ? DEPTH_DMEM : DEPTH_IB;
    w_len = {bus.rx_data, r_len_lo};
    w_last_byte = w_pay && int'(r_bcnt) == w_bpw - 1;
    w_last_word = w_last_byte && r_wcnt + 16'd1 == r_len;
    w_start = w_acc && r_state == LEN_HI && w_len != '0 && int'(w_len) <= w_depth;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = bus.abort ? IDLE :
             !bus.rx_vld ? r_state :
             r_state == IDLE ? (w_hdr_ok ? LEN_LO : IDLE) :
             r_state == LEN_LO ? LEN_HI :
             r_state == LEN_HI ? (w_start ? PAYLOAD : IDLE) :
             (w_last_word ? IDLE : PAYLOAD);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dest <= IMEM;
      r_len_lo <= '0;
      r_len <= '0;
      r_wcnt <= '0;
      r_bcnt <= '0;
      r_addr <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_acc && ((r_state == IDLE && !w_hdr_ok) || (r_state == LEN_HI && int'(w_len) > w_depth));
      r_done <= w_last_word || (w_acc && r_state == LEN_HI && w_len == '0);
      if (w_acc && r_state == IDLE && w_hdr_ok) r_dest <= dest_t'(bus.rx_data[2:0]);
      if (w_acc && r_state == LEN_LO) r_len_lo <= bus.rx_data;
      if (w_acc && r_state == LEN_HI) r_len <= w_len;
      r_bcnt <= (w_start || w_last_byte) ? '0 : w_pay ? r_bcnt + BW'(1) : r_bcnt;
      r_wcnt <= w_start ? '0 : w_last_byte ? r_wcnt + 16'd1 : r_wcnt;
      // the final word's strobe lands in IDLE, so the address stops at len-1
      r_addr <= w_start ? '0 : (w_rdy && r_state == PAYLOAD) ? r_addr + AW'(1) : r_addr;
    end
  end
  byte_packer #(.DW(DW), .BW(BW)) u_packer (
    .clk(clk),
    .rst_n(rst_n),
    .i_clr(w_start),
    .i_we(w_pay),
    .i_last(w_last_byte),
    .i_idx(r_bcnt),
    .i_byte(bus.rx_data),
    .o_word(w_word),
    .o_rdy(w_rdy)
  );
  always_comb begin
    bus.busy = r_state != IDLE;
    bus.done = r_done;
    bus.err = r_err;
    bus.imem_we = w_rdy && r_dest == IMEM;
    bus.dmem_we = w_rdy && r_dest == DMEM;
    bus.ib_we = w_rdy && r_dest == IB;
    bus.wr_addr = r_addr;
    bus.wr_data = w_word;
  end
endmodule

// File: tb/tb_boot_stream_loader.sv
// tb_boot_stream_loader: transfer-level reference model with per-cycle compare plus directed literal checks
module tb_boot_stream_loader;
  localparam int AW = 13;
  localparam int DW = 3072;
  typedef struct {int kind; int addr; logic [DW-1:0] data; logic done;} ev_t;
  logic clk, rst_n, chk_en;
  int n_err, n_chk, n_done, n_errp;
  ev_t log_q[$];
  logic [7:0] sq[$];
  logic [2:0] cur_we, nxt_we;
  logic [AW-1:0] cur_addr, nxt_addr;
  logic [DW-1:0] cur_data, nxt_data;
  logic cur_done, nxt_done, cur_err, nxt_err, cur_busy, nxt_busy;
  int m_phase, m_dest, m_lo, m_len, m_words;
  logic [7:0] m_q[$];
  boot_stream_loader_if #(.AW(AW), .DW(DW)) bus ();
  boot_stream_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int bpw_of(input int d);
    return d == 0 ? 4 : d == 1 ? 4 : 384;
  endfunction
  function automatic int depth_of(input int d);
    return d == 0 ? 2048 : d == 1 ? 8192 : 256;
  endfunction
  task automatic chk(input string name, input logic ok, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask
  task automatic model(input logic v, input logic [7:0] d, input logic a, input logic r);
    nxt_we = '0;
    nxt_done = 1'b0;
    nxt_err = 1'b0;
    nxt_addr = '0;
    nxt_data = '0;
    if (!r || a) begin
      m_phase = 0;
      m_q.delete();
    end else if (v) begin
      if (m_phase == 0) begin
        if (d == 8'h01 || d == 8'h02 || d == 8'h04) begin
          m_dest = d == 8'h04 ? 0 : d == 8'h02 ? 1 : 2;
          m_phase = 1;
        end else nxt_err = 1'b1;
      end else if (m_phase == 1) begin
        m_lo = int'(d);
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_len = int'(d) * 256 + m_lo;
        if (m_len > depth_of(m_dest)) begin
          nxt_err = 1'b1;
          m_phase = 0;
        end else if (m_len == 0) begin
          nxt_done = 1'b1;
          m_phase = 0;
        end else begin
          m_words = 0;
          m_q.delete();
          m_phase = 3;
        end
      end else begin
        m_q.push_back(d);
        if (m_q.size() == bpw_of(m_dest)) begin
          nxt_we[m_dest] = 1'b1;
          nxt_addr = AW'(m_words);
          foreach (m_q[i]) nxt_data[8*i +: 8] = m_q[i];
          m_q.delete();
          m_words++;
          if (m_words == m_len) begin
            nxt_done = 1'b1;
            m_phase = 0;
          end
        end
      end
    end
    nxt_busy = m_phase != 0;
  endtask
  task automatic tick(input logic v, input logic [7:0] d, input logic a, input logic r);
    bus.rx_vld = v;
    bus.rx_data = d;
    bus.abort = a;
    rst_n = r;
    model(v, d, a, r);
    @(posedge clk);
    cur_we = nxt_we;
    cur_addr = nxt_addr;
    cur_data = nxt_data;
    cur_done = nxt_done;
    cur_err = nxt_err;
    cur_busy = nxt_busy;
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b1);
  endtask
  task automatic send(input logic [7:0] b);
    tick(1'b1, b, 1'b0, 1'b1);
  endtask
  task automatic send_all();
    foreach (sq[i]) send(sq[i]);
  endtask
  task automatic clr_log();
    log_q.delete();
    n_done = 0;
    n_errp = 0;
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_we", bus.imem_we == cur_we[0], 64'(bus.imem_we), 64'(cur_we[0]));
      chk("dmem_we", bus.dmem_we == cur_we[1], 64'(bus.dmem_we), 64'(cur_we[1]));
      chk("ib_we", bus.ib_we == cur_we[2], 64'(bus.ib_we), 64'(cur_we[2]));
      chk("done", bus.done == cur_done, 64'(bus.done), 64'(cur_done));
      chk("err", bus.err == cur_err, 64'(bus.err), 64'(cur_err));
      chk("busy", bus.busy == cur_busy, 64'(bus.busy), 64'(cur_busy));
      if (cur_we != '0) begin
        chk("wr_addr", bus.wr_addr == cur_addr, 64'(bus.wr_addr), 64'(cur_addr));
        chk("wr_data", bus.wr_data == cur_data, bus.wr_data[63:0], cur_data[63:0]);
      end
      if (bus.imem_we || bus.dmem_we || bus.ib_we)
        log_q.push_back('{bus.ib_we ? 2 : bus.dmem_we ? 1 : 0, int'(bus.wr_addr), bus.wr_data, bus.done});
      if (bus.done) n_done++;
      if (bus.err) n_errp++;
    end
  end
  initial begin
    logic ok;
    int kind, dst, len, abort_at, reset_at, k;
    n_err = 0;
    n_chk = 0;
    chk_en = 1'b0;
    m_phase = 0;
    m_dest = 0;
    m_lo = 0;
    m_len = 0;
    m_words = 0;
    clr_log();
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk_en = 1'b1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);
    chk("rst_busy", bus.busy == 1'b0, 64'(bus.busy), 64'd0);
    chk("rst_wr_data", bus.wr_data == '0, bus.wr_data[63:0], 64'd0);
    // IMEM, two words
    clr_log();
    sq = '{8'h04, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_all();
    idle(3);
    chk("t1_count", log_q.size() == 2, 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("t1_kind", log_q[0].kind == 0 && log_q[1].kind == 0, 64'(log_q[1].kind), 64'd0);
      chk("t1_addr0", log_q[0].addr == 0, 64'(log_q[0].addr), 64'd0);
      chk("t1_data0", log_q[0].data == DW'(64'h44332211), log_q[0].data[63:0], 64'h44332211);
      chk("t1_addr1", log_q[1].addr == 1, 64'(log_q[1].addr), 64'd1);
      chk("t1_data1", log_q[1].data == DW'(64'h88776655), log_q[1].data[63:0], 64'h88776655);
      chk("t1_done_with_strobe", log_q[1].done && !log_q[0].done, 64'(log_q[1].done), 64'd1);
    end
    chk("t1_done_count", n_done == 1, 64'(n_done), 64'd1);
    // IB, one 384-byte word
    clr_log();
    sq = '{8'h01, 8'h01, 8'h00};
    send_all();
    for (int i = 0; i < 384; i++) send(8'(i));
    idle(3);
    chk("t2_count", log_q.size() == 1, 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("t2_kind", log_q[0].kind == 2, 64'(log_q[0].kind), 64'd2);
      chk("t2_low", log_q[0].data[63:0] == 64'h0706050403020100, log_q[0].data[63:0], 64'h0706050403020100);
      ok = 1'b1;
      for (int i = 0; i < 384; i++) if (log_q[0].data[8*i +: 8] != 8'(i)) ok = 1'b0;
      chk("t2_bytes", ok, 64'(ok), 64'd1);
    end
    chk("t2_done", n_done == 1, 64'(n_done), 64'd1);
    // illegal header, then DMEM over-length
    clr_log();
    send(8'h03);
    idle(2);
    chk("t3_err", n_errp == 1, 64'(n_errp), 64'd1);
    clr_log();
    sq = '{8'h02, 8'h01, 8'h20};
    send_all();
    idle(3);
    chk("t4_err", n_errp == 1, 64'(n_errp), 64'd1);
    chk("t4_nostrobe", log_q.size() == 0, 64'(log_q.size()), 64'd0);
    // DMEM zero length
    clr_log();
    sq = '{8'h02, 8'h00, 8'h00};
    send_all();
    idle(3);
    chk("t5_done", n_done == 1, 64'(n_done), 64'd1);
    chk("t5_nostrobe", log_q.size() == 0, 64'(log_q.size()), 64'd0);
    // DMEM abort mid second word, then restart
    clr_log();
    sq = '{8'h02, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_all();
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    idle(3);
    chk("t6_count", log_q.size() == 1, 64'(log_q.size()), 64'd1);
    chk("t6_nodone", n_done == 0, 64'(n_done), 64'd0);
    clr_log();
    sq = '{8'h02, 8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd};
    send_all();
    idle(3);
    chk("t6_restart_count", log_q.size() == 1, 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("t6_restart_addr", log_q[0].addr == 0, 64'(log_q[0].addr), 64'd0);
      chk("t6_restart_data", log_q[0].data == DW'(64'hddccbbaa), log_q[0].data[63:0], 64'hddccbbaa);
    end
    // reset on the fourth byte of an IMEM word
    clr_log();
    sq = '{8'h04, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    send_all();
    tick(1'b1, 8'h04, 1'b0, 1'b0);
    chk("t7_busy", bus.busy == 1'b0, 64'(bus.busy), 64'd0);
    idle(3);
    chk("t7_nostrobe", log_q.size() == 0, 64'(log_q.size()), 64'd0);
    // randomized transfers checked cycle by cycle against the model
    for (int t = 0; t < 40; t++) begin
      sq.delete();
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        k = $urandom_range(0, 255);
        while (k == 1 || k == 2 || k == 4) k = $urandom_range(0, 255);
        sq.push_back(8'(k));
      end else begin
        k = $urandom_range(0, 99);
        dst = k < 15 ? 2 : $urandom_range(0, 1);
        k = $urandom_range(0, 9);
        len = k == 0 ? 0 : k == 1 ? depth_of(dst) + $urandom_range(1, 3) :
              dst == 2 ? $urandom_range(1, 2) : $urandom_range(1, 4);
        sq.push_back(dst == 0 ? 8'h04 : dst == 1 ? 8'h02 : 8'h01);
        sq.push_back(8'(len));
        sq.push_back(8'(len >> 8));
        if (len <= depth_of(dst))
          for (int i = 0; i < len * bpw_of(dst); i++) sq.push_back(8'($urandom_range(0, 255)));
      end
      abort_at = $urandom_range(0, 9) == 0 ? $urandom_range(0, sq.size() - 1) : -1;
      reset_at = $urandom_range(0, 19) == 0 ? $urandom_range(0, sq.size() - 1) : -1;
      for (int i = 0; i < sq.size(); i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if (i == abort_at) begin
          tick(1'($urandom_range(0, 1)), sq[i], 1'b1, 1'b1);
          break;
        end
        if (i == reset_at) begin
          tick(1'($urandom_range(0, 1)), sq[i], 1'b0, 1'b0);
          break;
        end
        send(sq[i]);
      end
      idle($urandom_range(0, 2));
    end
    idle(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/boot_stream_loader.md
Name: boot_stream_loader

Overview:
Parametrised bootloader back end that turns a UART byte stream into word writes for instruction memory, data memory or the image buffer.
- Each transfer: one destination header byte, 16-bit word count (little-endian), payload bytes.
- Bytes are packed little-endian into a per-destination word width, and each word is written with a one-cycle strobe at an auto-incrementing address.
- Sits between the UART receiver and the three memory write ports; generalises the fixed 4-byte/384-byte bootloader widths to per-channel parameters, and adds length checking, abort and error reporting.

Parameters:
BPW_IMEM, 4, bytes per instruction-memory word
BPW_DMEM, 4, bytes per data-memory word
BPW_IB, 384, bytes per image-buffer word (3072 bits)
DEPTH_IMEM, 2048, instruction-memory words (11-bit address)
DEPTH_DMEM, 8192, data-memory words (13-bit address)
DEPTH_IB, 256, image-buffer words
AW, 13, wr_addr width; must satisfy 2**AW >= max depth
DW, 3072, wr_data width; must equal 8*max(BPW_*)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
abort  in  1  synchronous abort of the current transfer
rx_vld  in  1  one-cycle strobe: rx_data holds a valid byte
rx_data  in  8  received byte
imem_we  out  1  instruction-memory write strobe
dmem_we  out  1  data-memory write strobe
ib_we  out  1  image-buffer write strobe
wr_addr  out  AW  word address for the current strobe
wr_data  out  DW  assembled word; bits above 8*BPW of the destination are 0
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a transfer completes
err  out  1  one-cycle pulse when a transfer is rejected

Behaviour:
- Reset: synchronous on the clk edge with rst_n=0. Every output is 0 and the state is IDLE. Reset mid-payload drops the partial word and issues no strobe.
- Header encodings: 3'b100 selects IMEM, 3'b010 DMEM, 3'b001 IB, all in rx_data[2:0]. rx_data[7:3] must be 0.
- State machine:
  - IDLE: on rx_vld, a legal header latches dest and moves to LEN_LO. Any other byte pulses err on the next cycle and stays in IDLE.
  - LEN_LO: on rx_vld, latch len[7:0] and move to LEN_HI.
  - LEN_HI: on rx_vld, latch len[15:8], then check:
    - len > DEPTH of dest: pulse err and go to IDLE.
    - len == 0: pulse done and go to IDLE.
    - otherwise: clear the byte counter, word counter and wr_addr, and go to PAYLOAD.
  - PAYLOAD: each rx_vld writes rx_data into byte lane bcnt (bits 8*bcnt+7 : 8*bcnt) of the assembly register, then bcnt++.
    - When bcnt == BPW(dest)-1, the next cycle asserts exactly one of imem_we/dmem_we/ib_we for one cycle, with wr_addr and wr_data stable in that cycle.
    - bcnt then clears and the assembly register is zeroed.
    - wr_addr increments the cycle after the strobe.
  - Completion: when the written word count reaches len, done pulses in the same cycle as the final strobe and the state returns to IDLE.
- Latency: the strobe comes 1 cycle after the last byte of a word is accepted.
- Throughput: back-to-back rx_vld is accepted in every state; the strobe cycle may coincide with acceptance of the next word's first byte.
- abort: in any state, returns to IDLE the next cycle.
  - No strobe is issued for a partial word and done is not pulsed.
  - abort has priority over a same-cycle rx_vld and over a same-cycle word completion (that write is suppressed).
- Ordering: rx_vld while a strobe is pending is never lost. The assembly register and the write register are separate.
- Address range: wr_addr never exceeds len-1, so no wrap-around is possible once the length check has passed.

Decomposition:
- Shared package gets:
  - dest_t enum {IMEM=3'b100, DMEM=3'b010, IB=3'b001}
  - boot_state_t {IDLE, LEN_LO, LEN_HI, PAYLOAD}
  - default BPW and DEPTH constants
- Sub-module byte_packer (parameter DW): byte-lane write by index, clear, and a word-ready flag. The FSM, counters and length check stay in the top module.

Test Plan:
- IMEM, len=2, bytes 04 02 00 11 22 33 44 55 66 77 88 -> imem_we at addr 0 with data 0x44332211, then addr 1 with 0x88776655. done pulses with the second strobe.
- IB, len=1, 384 bytes of value i mod 256 -> a single ib_we at addr 0. wr_data byte k equals k mod 256. done pulses.
- Header 0x03 -> err pulse 1 cycle later and busy stays 0. DMEM with len=8193 -> err after LEN_HI and no strobe.
- DMEM with len=0 (02 00 00) -> done pulses after LEN_HI and no dmem_we.
- DMEM, len=2: abort after byte 6 -> one dmem_we (addr 0), no second strobe, no done. The next transfer restarts at addr 0.
- rst_n low on the same cycle as the 4th byte of an IMEM word -> no imem_we, all outputs 0, state IDLE.
